// File: rtl/sonic_pkg.sv
// Shared constants and FSM state encodings for the ultrasonic ranging blocks.
// Used by sonic_echo_responder and the sonic_top initiator.
package sonic_pkg;

    localparam int TRIG_MIN_CYC    = 1000;
    localparam int BURST_DELAY_CYC = 20000;
    localparam int CYC_PER_CM      = 5800;
    localparam int MAX_ECHO_CYC    = 3800000;
    localparam int HOLDOFF_CYC     = 1000000;
    localparam int DIST_W          = 9;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_TRIG_HI = 3'd1;
    localparam logic [2:0] ST_BURST   = 3'd2;
    localparam logic [2:0] ST_ECHO    = 3'd3;
    localparam logic [2:0] ST_HOLDOFF = 3'd4;

endpackage

// File: rtl/sonic_echo_responder_sync_edge_det.sv
// Two-flop synchroniser with registered rise/fall pulses.
// Ports: clk, rst (sync, active-high), i_sig (async in), o_rise, o_fall.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_sync_q;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_q <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_meta   <= i_sig;
            r_sync   <= r_meta;
            r_sync_q <= r_sync;
            r_rise   <= r_sync & ~r_sync_q;
            r_fall   <= ~r_sync & r_sync_q;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/sonic_echo_responder.sv
// HC-SR04 emulator: accepts Trig, waits a burst delay, then drives an Echo
// pulse whose width encodes distance_cm. Ports: clk, rst (sync, active-high),
// trig, distance_cm, dist_valid -> echo, busy, trig_err, meas_count.
// Build option SONIC_JITTER_EN adds 0..255 LFSR cycles to each echo width.
module sonic_echo_responder
    import sonic_pkg::*;
#(
    parameter int TRIG_MIN_CYC    = sonic_pkg::TRIG_MIN_CYC,
    parameter int BURST_DELAY_CYC = sonic_pkg::BURST_DELAY_CYC,
    parameter int CYC_PER_CM      = sonic_pkg::CYC_PER_CM,
    parameter int DIST_W          = sonic_pkg::DIST_W,
    parameter int MAX_ECHO_CYC    = sonic_pkg::MAX_ECHO_CYC,
    parameter int HOLDOFF_CYC     = sonic_pkg::HOLDOFF_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [DIST_W-1:0] distance_cm,
    input  logic              dist_valid,
    output logic              echo,
    output logic              busy,
    output logic              trig_err,
    output logic [15:0]       meas_count
);

`ifdef SONIC_JITTER_EN
    localparam int ECHO_W = $clog2(MAX_ECHO_CYC + 256);
`else
    localparam int ECHO_W = $clog2(MAX_ECHO_CYC + 1);
`endif
    localparam int HI_W    = $clog2(TRIG_MIN_CYC + 1);
    localparam int DLY_MAX = (BURST_DELAY_CYC > HOLDOFF_CYC) ?
                             BURST_DELAY_CYC : HOLDOFF_CYC;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);

    logic              w_rise;
    logic              w_fall;
    logic [DIST_W-1:0] w_cm;
    logic [ECHO_W-1:0] w_width;

    logic [2:0]        r_state;
    logic [HI_W-1:0]   r_hi_cnt;
    logic [DLY_W-1:0]  r_dly;
    logic [ECHO_W-1:0] r_echo_cnt;
    logic              r_trig_err;
    logic [15:0]       r_meas;

    sync_edge_det u_trig_sync (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (trig),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

`ifdef SONIC_JITTER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0],
                       r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end
`endif

    // 0 cm would give a zero-width echo; clamp to 1 cm.
    assign w_cm = (distance_cm == '0) ? DIST_W'(1) : distance_cm;

    always_comb begin
        if (dist_valid) begin
            w_width = ECHO_W'(w_cm) * ECHO_W'(CYC_PER_CM);
        end else begin
            w_width = ECHO_W'(MAX_ECHO_CYC);
        end
`ifdef SONIC_JITTER_EN
        w_width = w_width + ECHO_W'(r_lfsr[7:0]);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hi_cnt   <= '0;
            r_dly      <= '0;
            r_echo_cnt <= '0;
            r_trig_err <= 1'b0;
            r_meas     <= '0;
        end else begin
            r_trig_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state  <= ST_TRIG_HI;
                        r_hi_cnt <= HI_W'(1);
                    end
                end
                ST_TRIG_HI: begin
                    if (w_fall) begin
                        if (r_hi_cnt >= HI_W'(TRIG_MIN_CYC)) begin
                            r_state    <= ST_BURST;
                            r_dly      <= DLY_W'(BURST_DELAY_CYC - 1);
                            r_echo_cnt <= w_width;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_trig_err <= 1'b1;
                        end
                    end else if (r_hi_cnt != HI_W'(TRIG_MIN_CYC)) begin
                        r_hi_cnt <= r_hi_cnt + HI_W'(1);
                    end
                end
                ST_BURST: begin
                    if (r_dly == '0) begin
                        r_state <= ST_ECHO;
                    end else begin
                        r_dly <= r_dly - DLY_W'(1);
                    end
                end
                ST_ECHO: begin
                    // Leave on the last high cycle so echo spans exactly
                    // the loaded width.
                    if (r_echo_cnt <= ECHO_W'(1)) begin
                        r_state <= ST_HOLDOFF;
                        r_meas  <= r_meas + 16'd1;
                        r_dly   <= DLY_W'(HOLDOFF_CYC - 1);
                    end else begin
                        r_echo_cnt <= r_echo_cnt - ECHO_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (r_dly == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_dly <= r_dly - DLY_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign echo       = (r_state == ST_ECHO);
    assign busy       = (r_state != ST_IDLE);
    assign trig_err   = r_trig_err;
    assign meas_count = r_meas;

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Directed self-checking bench for sonic_echo_responder with scaled-down
// timing parameters so every scenario completes in a few thousand cycles.
module tb_sonic_echo_responder;

    localparam int TMIN = 10;
    localparam int BD   = 50;
    localparam int CPC  = 4;
    localparam int MAXE = 3000;
    localparam int HOLD = 100;
    localparam int LAT  = BD + 3;

    logic        clk;
    logic        rst;
    logic        trig;
    logic [8:0]  distance_cm;
    logic        dist_valid;
    logic        echo;
    logic        busy;
    logic        trig_err;
    logic [15:0] meas_count;

    int n_assert;
    int n_fail;
    int lat;
    int wid;
    int errs;
    int echo_seen;
    int got_echo;

    sonic_echo_responder #(
        .TRIG_MIN_CYC    (TMIN),
        .BURST_DELAY_CYC (BD),
        .CYC_PER_CM      (CPC),
        .DIST_W          (9),
        .MAX_ECHO_CYC    (MAXE),
        .HOLDOFF_CYC     (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trig        (trig),
        .distance_cm (distance_cm),
        .dist_valid  (dist_valid),
        .echo        (echo),
        .busy        (busy),
        .trig_err    (trig_err),
        .meas_count  (meas_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse trig for n_hi clocks, then measure fall-to-echo latency and
    // echo width. distance_cm is disturbed after the latch point; with poke
    // set a second Trig pulse is driven while echo is high.
    task automatic pulse_measure(input int n_hi, input int cm,
                                 input logic valid, input bit poke,
                                 output int o_lat, output int o_wid);
        @(negedge clk);
        distance_cm = 9'(cm);
        dist_valid  = valid;
        trig        = 1'b1;
        repeat (n_hi) @(negedge clk);
        trig  = 1'b0;
        o_lat = -1;
        o_wid = -1;
        for (int c = 1; c <= BD + 200; c++) begin
            @(posedge clk);
            #1;
            if (c == 10) distance_cm = 9'd200;
            if (echo) begin
                o_lat = c - 1;
                break;
            end
        end
        if (o_lat >= 0) begin
            for (int w = 1; w <= MAXE + 200; w++) begin
                @(posedge clk);
                #1;
                if (poke && w == 20) trig = 1'b1;
                if (poke && w == 30) trig = 1'b0;
                if (!echo) begin
                    o_wid = w;
                    break;
                end
            end
        end
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        trig        = 1'b0;
        distance_cm = '0;
        dist_valid  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_echo", int'(echo), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(trig_err), 0);
        chk("rst_meas", int'(meas_count), 0);

        pulse_measure(TMIN, 30, 1'b1, 1'b0, lat, wid);
        chk("t1_lat", lat, LAT);
        chk("t1_width", wid, 30 * CPC);
        chk("t1_meas", int'(meas_count), 1);
        chk("t1_busy_hold", int'(busy), 1);
        repeat (HOLD + 10) @(negedge clk);
        chk("t1_busy_idle", int'(busy), 0);

        @(negedge clk);
        trig = 1'b1;
        repeat (TMIN - 1) @(negedge clk);
        trig      = 1'b0;
        errs      = 0;
        echo_seen = 0;
        repeat (BD + 50) begin
            @(posedge clk);
            #1;
            errs      += int'(trig_err);
            echo_seen |= int'(echo);
        end
        chk("t2_err_cycles", errs, 1);
        chk("t2_no_echo", echo_seen, 0);
        chk("t2_busy", int'(busy), 0);

        pulse_measure(TMIN, 30, 1'b0, 1'b0, lat, wid);
        chk("t3_nv_lat", lat, LAT);
        chk("t3_nv_width", wid, MAXE);
        repeat (HOLD + 10) @(negedge clk);
        pulse_measure(TMIN, 0, 1'b1, 1'b0, lat, wid);
        chk("t3_zero_width", wid, CPC);
        chk("t3_meas", int'(meas_count), 3);
        repeat (HOLD + 10) @(negedge clk);

        pulse_measure(TMIN, 30, 1'b1, 1'b1, lat, wid);
        chk("t4_width", wid, 30 * CPC);
        @(negedge clk);
        trig = 1'b1;
        repeat (TMIN) @(negedge clk);
        trig      = 1'b0;
        echo_seen = 0;
        repeat (HOLD + 50) begin
            @(posedge clk);
            #1;
            echo_seen |= int'(echo);
        end
        chk("t4_hold_echo", echo_seen, 0);
        chk("t4_meas", int'(meas_count), 4);
        chk("t4_busy", int'(busy), 0);

        @(negedge clk);
        distance_cm = 9'd30;
        dist_valid  = 1'b1;
        trig        = 1'b1;
        repeat (TMIN) @(negedge clk);
        trig     = 1'b0;
        got_echo = 0;
        for (int c = 0; c < BD + 200; c++) begin
            @(posedge clk);
            #1;
            if (echo) begin
                got_echo = 1;
                break;
            end
        end
        chk("t5_echo_start", got_echo, 1);
        repeat (100) @(posedge clk);
        #1;
        chk("t5_echo_mid", int'(echo), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_rst_echo", int'(echo), 0);
        chk("t5_rst_meas", int'(meas_count), 0);
        chk("t5_rst_busy", int'(busy), 0);
        pulse_measure(TMIN, 511, 1'b1, 1'b0, lat, wid);
        chk("t5_lat", lat, LAT);
        chk("t5_width", wid, 511 * CPC);
        chk("t5_meas", int'(meas_count), 1);
        repeat (HOLD + 10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
